wallace_cpa_pipe: RTL and testbench

- Downstream neighbour of the MAC Wallace tree.
- Consumes the redundant sum/carry vector pair plus the sign-extension suppression flag.
- Resolves them with a two-stage pipelined carry-propagate adder into one binary product vector.
- Valid/ready elastic handshake on both sides; feeds normalisation/accumulate logic.

---
 rtl/wallace_cpa_pipe.sv | 147 ++++++++++++++
 tb/tb_wallace_cpa_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_cpa_pipe.sv
// rtl/wallace_cpa_pipe.sv - two-stage pipelined carry-propagate adder resolving Wallace sum/carry pairs
// Optional zero flag output enabled by defining WALLACE_CPA_ZERO_FLAG_EN.
module wallace_cpa_pipe #(
    parameter int  PARM_MANT = 23,
    parameter int  PARM_LO   = PARM_MANT + 2,
    localparam int W         = 2 * PARM_MANT + 3,
    localparam int HW        = W - PARM_LO
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] sum_i,
    input  logic [W-1:0] carry_i,
    input  logic         msb_cor_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] product_o,
    output logic         cout_o,
`ifdef WALLACE_CPA_ZERO_FLAG_EN
    output logic         zero_o,
`endif
    output logic         msb_cor_o
);

    // Stage 1: low slice resolved, high slices carried along untouched.
    logic               s1_v_q,      s1_v_d;
    logic [PARM_LO-1:0] lo_sum_q,    lo_sum_d;
    logic               lo_cout_q,   lo_cout_d;
    logic [HW-1:0]      hi_sum_q,    hi_sum_d;
    logic [HW-1:0]      hi_carry_q,  hi_carry_d;
    logic               s1_msb_q,    s1_msb_d;

    // Stage 2: fully resolved product.
    logic               s2_v_q,      s2_v_d;
    logic [W-1:0]       product_q,   product_d;
    logic               cout_q,      cout_d;
    logic               msb_q,       msb_d;
`ifdef WALLACE_CPA_ZERO_FLAG_EN
    logic               zero_q,      zero_d;
`endif

    logic               s1_load;
    logic               s2_load;
    logic [PARM_LO:0]   lo_add;
    logic [HW:0]        hi_add;

    always_comb begin
        s2_load = s1_v_q & (~s2_v_q | ready_i);
        s1_load = valid_i & (~s1_v_q | s2_load);
    end

    assign ready_o = ~s1_v_q | ~s2_v_q | ready_i;

    always_comb begin
        lo_add = {1'b0, sum_i[PARM_LO-1:0]} + {1'b0, carry_i[PARM_LO-1:0]};
        hi_add = {1'b0, hi_sum_q} + {1'b0, hi_carry_q} + {{HW{1'b0}}, lo_cout_q};
    end

    always_comb begin
        s1_v_d     = s1_v_q;
        lo_sum_d   = lo_sum_q;
        lo_cout_d  = lo_cout_q;
        hi_sum_d   = hi_sum_q;
        hi_carry_d = hi_carry_q;
        s1_msb_d   = s1_msb_q;
        if (s1_load) begin
            s1_v_d     = 1'b1;
            lo_sum_d   = lo_add[PARM_LO-1:0];
            lo_cout_d  = lo_add[PARM_LO];
            hi_sum_d   = sum_i[W-1:PARM_LO];
            hi_carry_d = carry_i[W-1:PARM_LO];
            s1_msb_d   = msb_cor_i;
        end else if (s2_load) begin
            s1_v_d = 1'b0;
        end
    end

    // A stalled output keeps its data; it only drains when downstream takes it.
    always_comb begin
        s2_v_d    = s2_v_q;
        product_d = product_q;
        cout_d    = cout_q;
        msb_d     = msb_q;
`ifdef WALLACE_CPA_ZERO_FLAG_EN
        zero_d    = zero_q;
`endif
        if (s2_load) begin
            s2_v_d    = 1'b1;
            product_d = {hi_add[HW-1:0], lo_sum_q};
            cout_d    = hi_add[HW];
            msb_d     = s1_msb_q;
`ifdef WALLACE_CPA_ZERO_FLAG_EN
            zero_d    = ~(|{hi_add[HW-1:0], lo_sum_q});
`endif
        end else if (ready_i) begin
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_v_q     <= 1'b0;
            lo_sum_q   <= '0;
            lo_cout_q  <= 1'b0;
            hi_sum_q   <= '0;
            hi_carry_q <= '0;
            s1_msb_q   <= 1'b0;
        end else begin
            s1_v_q     <= s1_v_d;
            lo_sum_q   <= lo_sum_d;
            lo_cout_q  <= lo_cout_d;
            hi_sum_q   <= hi_sum_d;
            hi_carry_q <= hi_carry_d;
            s1_msb_q   <= s1_msb_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_v_q    <= 1'b0;
            product_q <= '0;
            cout_q    <= 1'b0;
            msb_q     <= 1'b0;
`ifdef WALLACE_CPA_ZERO_FLAG_EN
            zero_q    <= 1'b0;
`endif
        end else begin
            s2_v_q    <= s2_v_d;
            product_q <= product_d;
            cout_q    <= cout_d;
            msb_q     <= msb_d;
`ifdef WALLACE_CPA_ZERO_FLAG_EN
            zero_q    <= zero_d;
`endif
        end
    end

    assign valid_o   = s2_v_q;
    assign product_o = product_q;
    assign cout_o    = cout_q;
    assign msb_cor_o = msb_q;
`ifdef WALLACE_CPA_ZERO_FLAG_EN
    assign zero_o    = zero_q;
`endif

endmodule

// File: tb/tb_wallace_cpa_pipe.sv
// tb/tb_wallace_cpa_pipe.sv - self-checking bench for wallace_cpa_pipe
module tb_wallace_cpa_pipe;
    localparam int W = 49;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] sum_i = '0;
    logic [W-1:0] carry_i = '0;
    logic         msb_cor_i = 1'b0;
    logic         valid_o;
    logic         ready_i = 1'b1;
    logic [W-1:0] product_o;
    logic         cout_o;
    logic         msb_cor_o;
`ifdef WALLACE_CPA_ZERO_FLAG_EN
    logic         zero_o;
`endif

    wallace_cpa_pipe dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .sum_i(sum_i), .carry_i(carry_i), .msb_cor_i(msb_cor_i),
        .valid_o(valid_o), .ready_i(ready_i), .product_o(product_o),
        .cout_o(cout_o),
`ifdef WALLACE_CPA_ZERO_FLAG_EN
        .zero_o(zero_o),
`endif
        .msb_cor_o(msb_cor_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic         m;
        logic [W-1:0] p;
        logic         co;
    } vec_t;

    typedef struct {
        logic [W-1:0] p;
        logic         co;
        logic         m;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    int   out_cnt = 0;
    res_t exp_q[$];
    res_t pend;
    res_t head;
    logic         stall_prev = 1'b0;
    logic [W-1:0] prod_prev;
    logic         cout_prev;
    logic         msb_prev;
    logic         rnd_done;
    vec_t         tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Scoreboard: outputs taken at a handshake are compared against accepted inputs in order.
    always @(negedge clk) begin
        if (rst_i) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", valid_o, 1);
                chk("hold_product", product_o, prod_prev);
                chk("hold_cout", cout_o, cout_prev);
                chk("hold_msb", msb_cor_o, msb_prev);
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", product_o);
                end else begin
                    head = exp_q.pop_front();
                    chk("product", product_o, head.p);
                    chk("cout", cout_o, head.co);
                    chk("msb_cor", msb_cor_o, head.m);
`ifdef WALLACE_CPA_ZERO_FLAG_EN
                    chk("zero", zero_o, (head.p == '0) ? 1 : 0);
`endif
                end
                out_cnt++;
            end
            stall_prev = valid_o && !ready_i;
            prod_prev  = product_o;
            cout_prev  = cout_o;
            msb_prev   = msb_cor_o;
            if (valid_i && ready_o) exp_q.push_back(pend);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the transfer edge with valid_i still high.
    task automatic send(input logic [W-1:0] s, input logic [W-1:0] c, input logic m,
                        input logic [W-1:0] p, input logic co);
        int n = 0;
        sum_i = s; carry_i = c; msb_cor_i = m;
        pend.p = p; pend.co = co; pend.m = m;
        valid_i = 1'b1;
        @(negedge clk);
        while (!ready_o && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!ready_o) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic sendr(input logic [W-1:0] s, input logic [W-1:0] c, input logic m);
        logic [W:0] r;
        r = ref_add(s, c);
        send(s, c, m, r[W-1:0], r[W]);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || valid_o) && n < 500) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        time t0;
        tbl[0] = '{49'h1, 49'h1, 1'b1, 49'h2, 1'b0};
        tbl[1] = '{49'h1FFFFFF, 49'h1, 1'b0, 49'h2000000, 1'b0};
        tbl[2] = '{49'h1FFFFFFFFFFFF, 49'h1, 1'b1, 49'h0, 1'b1};
        tbl[3] = '{49'h1FFFFFFFFFFFF, 49'h1FFFFFFFFFFFF, 1'b0, 49'h1FFFFFFFFFFFE, 1'b1};
        tbl[4] = '{49'h0, 49'h0, 1'b1, 49'h0, 1'b0};
        tbl[5] = '{49'h1000000, 49'h1000000, 1'b0, 49'h2000000, 1'b0};
        tbl[6] = '{49'h1000000000000, 49'h1000000000000, 1'b1, 49'h0, 1'b1};
        tbl[7] = '{49'h123456789ABC, 49'h0EDCBA987654, 1'b0, 49'h211111111110, 1'b0};

        // Reset with operands presented: nothing captured until reset is released.
        sum_i = 49'h1; carry_i = 49'h1; msb_cor_i = 1'b1; valid_i = 1'b1;
        pend.p = 49'h2; pend.co = 1'b0; pend.m = 1'b1;
        @(posedge clk); #1;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_ready_o", ready_o, 1);
        chk("rst_product", product_o, 0);
        chk("rst_cout", cout_o, 0);
        chk("rst_msb", msb_cor_o, 0);
        @(posedge clk); #1;
        chk("rst_no_capture", valid_o, 0);
        rst_i = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b0;
        chk("latency_cycle1", valid_o, 0);
        @(posedge clk); #1;
        chk("latency_cycle2", valid_o, 1);
        chk("basic_product", product_o, 2);
        drain();

        // Table vectors streamed back to back.
        c0 = out_cnt;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send(tbl[i].s, tbl[i].c, tbl[i].m, tbl[i].p, tbl[i].co);
        valid_i = 1'b0;
        drain();
        chk("table_count", out_cnt - c0, 8);

        // Backpressure: A and B fill the pipe, C is held off.
        ready_i = 1'b0;
        @(posedge clk); #1;
        sendr(49'd5, 49'd3, 1'b0);
        sendr(49'd7, 49'd0, 1'b1);
        sum_i = 49'd1; carry_i = 49'd1; msb_cor_i = 1'b0; valid_i = 1'b1;
        pend.p = 49'd2; pend.co = 1'b0; pend.m = 1'b0;
        chk("bp_ready_low", ready_o, 0);
        chk("bp_valid", valid_o, 1);
        chk("bp_head", product_o, 8);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_stall_product", product_o, 8);
            chk("bp_stall_ready", ready_o, 0);
        end
        ready_i = 1'b1;
        @(negedge clk);
        chk("bp_out0_valid", valid_o, 1);
        chk("bp_out0", product_o, 8);
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(negedge clk);
        chk("bp_out1_valid", valid_o, 1);
        chk("bp_out1", product_o, 7);
        @(negedge clk);
        chk("bp_out2_valid", valid_o, 1);
        chk("bp_out2", product_o, 2);
        @(posedge clk); #1;
        drain();

        // Streaming: 16 random pairs with no backpressure, one per cycle.
        c0 = out_cnt;
        @(posedge clk); #1;
        t0 = $time;
        for (int i = 0; i < 16; i++)
            sendr({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        valid_i = 1'b0;
        chk("stream_cycles", ($time - t0) / 10, 16);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("stream_count", out_cnt - c0, 16);
        drain();

        // Random valid gaps and random backpressure.
        c0 = out_cnt;
        rnd_done = 1'b0;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    sendr({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
                    valid_i = 1'b0;
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ready_i = 1'b1;
        drain();
        chk("random_count", out_cnt - c0, 40);

        // Reset mid-operation with both stages full and stalled.
        ready_i = 1'b0;
        @(posedge clk); #1;
        sendr(49'h111, 49'h222, 1'b1);
        sendr(49'h333, 49'h444, 1'b1);
        valid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        chk("midrst_valid", valid_o, 0);
        chk("midrst_product", product_o, 0);
        chk("midrst_cout", cout_o, 0);
        chk("midrst_msb", msb_cor_o, 0);
        chk("midrst_ready", ready_o, 1);
        exp_q.delete();
        #4;
        rst_i = 1'b0;
        ready_i = 1'b1;
        c0 = out_cnt;
        @(posedge clk); #1;
        sendr(49'h5A5A5A5A5A5A, 49'h0A0A0A0A0A0A, 1'b0);
        valid_i = 1'b0;
        drain();
        chk("midrst_out_count", out_cnt - c0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
